// File: rtl/peridot_config_pkg.sv
// PERIDOT config-layer shared definitions.
// Protocol bytes, FSM encoding, config/response bit positions.
package peridot_config_pkg;

  localparam logic [7:0] CMD_BYTE = 8'h3A;
  localparam logic [7:0] ESC_BYTE = 8'h3D;
  localparam logic [7:0] ESC_XOR  = 8'h20;

  localparam int CFG_NCONFIG = 0;
  localparam int CFG_FT_SI   = 1;
  localparam int CFG_MODE    = 3;
  localparam int CFG_SCL     = 4;
  localparam int CFG_SDA     = 5;

  localparam int RSP_BOOTSEL  = 0;
  localparam int RSP_NSTATUS0 = 1;
  localparam int RSP_NSTATUS1 = 2;
  localparam int RSP_SCL      = 4;
  localparam int RSP_SDA      = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ESC2,
    ST_CMD1,
    ST_CMD2,
    ST_WAITRESP
  } state_t;

  function automatic logic needs_esc(
    input logic [7:0] b
  );
    return (b == CMD_BYTE) ||
           (b == ESC_BYTE);
  endfunction

endpackage

// File: rtl/peridot_config_timeout.sv
// Response timeout: loadable down-counter.
// Holds at zero; expired while zero.
module peridot_config_timeout (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic        en,
  output logic        expired
);

  logic [31:0] cnt_q;

  // load on command ack, count down while waiting
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 32'd1;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/peridot_config_host.sv
// PERIDOT config-layer host initiator.
// Escapes outbound data, issues commands, captures responses.
module peridot_config_host
  import peridot_config_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic       in_ready,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       tx_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  output logic       rx_ready,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_data,
  output logic       resp_valid,
  output logic [7:0] resp_data,
  output logic       resp_timeout
);

  localparam logic [31:0] TO_LOAD =
    32'(TIMEOUT_CYCLES - 1);

  state_t     state_q;
  state_t     state_d;
  logic [7:0] esc_q;
  logic [7:0] cmd_q;
  logic       esc_ld;
  logic       cmd_ld;
  logic       to_load;
  logic       to_en;
  logic       to_expired;
  logic       resp_set;
  logic       resp_to;

  peridot_config_timeout u_timeout (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (to_load),
    .load_val (TO_LOAD),
    .en       (to_en),
    .expired  (to_expired)
  );

  // state, latched bytes and response registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      esc_q        <= '0;
      cmd_q        <= '0;
      resp_valid   <= 1'b0;
      resp_timeout <= 1'b0;
      resp_data    <= '0;
    end else begin
      state_q    <= state_d;
      resp_valid <= resp_set;
      if (esc_ld) begin
        esc_q <= in_data ^ ESC_XOR;
      end
      if (cmd_ld) begin
        cmd_q <= cmd_data;
      end
      if (resp_set) begin
        resp_timeout <= resp_to;
        resp_data    <= resp_to ? 8'h00
                                : rx_data;
      end
    end
  end

  // next state and handshake steering
  always_comb begin
    state_d   = state_q;
    tx_valid  = 1'b0;
    tx_data   = in_data;
    in_ready  = 1'b0;
    rx_ready  = out_ready;
    out_valid = rx_valid;
    out_data  = rx_data;
    cmd_ready = 1'b0;
    esc_ld    = 1'b0;
    cmd_ld    = 1'b0;
    to_load   = 1'b0;
    to_en     = 1'b0;
    resp_set  = 1'b0;
    resp_to   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          cmd_ready = 1'b1;
          cmd_ld    = 1'b1;
          state_d   = ST_CMD1;
        end else begin
          in_ready = tx_ready;
          tx_valid = in_valid;
          if (needs_esc(in_data)) begin
            tx_data = ESC_BYTE;
            if (in_valid && tx_ready) begin
              esc_ld  = 1'b1;
              state_d = ST_ESC2;
            end
          end
        end
      end
      ST_ESC2: begin
        tx_valid = 1'b1;
        tx_data  = esc_q;
        if (tx_ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_CMD1: begin
        tx_valid = 1'b1;
        tx_data  = CMD_BYTE;
        if (tx_ready) begin
          state_d = ST_CMD2;
        end
      end
      ST_CMD2: begin
        tx_valid = 1'b1;
        tx_data  = cmd_q;
        if (tx_ready) begin
          to_load = 1'b1;
          state_d = ST_WAITRESP;
        end
      end
      ST_WAITRESP: begin
        rx_ready  = 1'b1;
        out_valid = 1'b0;
        if (rx_valid) begin
          resp_set = 1'b1;
          state_d  = ST_IDLE;
        end else if (to_expired) begin
          resp_set = 1'b1;
          resp_to  = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          to_en = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_peridot_config_host.sv
// Directed bench for peridot_config_host.
// TIMEOUT_CYCLES = 16; link byte monitor plus stall checker.
module tb_peridot_config_host;

  logic       clk;
  logic       reset_n;
  logic       in_ready;
  logic       in_valid;
  logic [7:0] in_data;
  logic       tx_ready;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       rx_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_data;
  logic       resp_valid;
  logic [7:0] resp_data;
  logic       resp_timeout;

  int errs   = 0;
  int checks = 0;
  int resp_cnt = 0;
  logic [7:0] txq[$];
  bit   rand_rdy   = 0;
  bit   chk_stable = 0;
  logic stall_q = 1'b0;
  logic [7:0] stall_d = 8'h00;

  peridot_config_host #(
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_ready     (in_ready),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .tx_ready     (tx_ready),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .rx_ready     (rx_ready),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_data     (cmd_data),
    .resp_valid   (resp_valid),
    .resp_data    (resp_data),
    .resp_timeout (resp_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic exp_tx(
    input string      tag,
    input logic [7:0] b
  );
    logic [7:0] got;
    if (txq.size() == 0) begin
      got = 8'hxx;
    end else begin
      got = txq.pop_front();
    end
    chk(tag, {24'h0, got}, {24'h0, b});
  endtask

  task automatic send(input logic [7:0] b);
    bit done;
    done = 0;
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("send_accept", 32'(done), 32'd1);
  endtask

  // record every accepted link byte and response pulse
  always @(posedge clk) begin
    if (reset_n && tx_valid && tx_ready)
      txq.push_back(tx_data);
    if (reset_n && resp_valid)
      resp_cnt <= resp_cnt + 1;
  end

  // a stalled link beat must be held unchanged
  always @(posedge clk) begin
    if (chk_stable && stall_q) begin
      chk("stall_valid", 32'(tx_valid), 32'd1);
      chk("stall_data", 32'(tx_data),
          32'(stall_d));
    end
    stall_q <= chk_stable && reset_n &&
               tx_valid && !tx_ready;
    stall_d <= tx_data;
  end

  // random link back-pressure
  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      tx_ready = 1'($urandom);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int  c0;
    bit  got;
    reset_n   = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    tx_ready  = 1'b1;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    out_ready = 1'b1;
    cmd_valid = 1'b0;
    cmd_data  = 8'h00;
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_rx_ready", 32'(rx_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_cmd_ready", 32'(cmd_ready), 0);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_resp_to", 32'(resp_timeout), 0);
    chk("rst_resp_data", 32'(resp_data), 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // escaped data stream
    txq.delete();
    send(8'h00);
    send(8'h3A);
    chk("esc2_valid", 32'(tx_valid), 1);
    chk("esc2_data", 32'(tx_data), 32'h1A);
    chk("esc2_in_ready", 32'(in_ready), 0);
    send(8'h41);
    send(8'h3D);
    @(posedge clk);
    #1;
    exp_tx("s1_b0", 8'h00);
    exp_tx("s1_b1", 8'h3D);
    exp_tx("s1_b2", 8'h1A);
    exp_tx("s1_b3", 8'h41);
    exp_tx("s1_b4", 8'h3D);
    exp_tx("s1_b5", 8'h1D);
    chk("s1_len", txq.size(), 0);

    // command beats pending data, then response
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h55;
    cmd_valid = 1'b1;
    cmd_data  = 8'h39;
    @(negedge clk);
    chk("c1_cmd_ready", 32'(cmd_ready), 1);
    chk("c1_in_ready", 32'(in_ready), 0);
    chk("c1_tx_valid", 32'(tx_valid), 0);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk("c1_ready_pulse", 32'(cmd_ready), 0);
    chk("c1_cmd1_data", 32'(tx_data), 32'h3A);
    chk("c1_cmd1_in_rdy", 32'(in_ready), 0);
    @(posedge clk);
    #1;
    chk("c1_cmd2_data", 32'(tx_data), 32'h39);
    @(posedge clk);
    #1;
    chk("c1_wait_tx", 32'(tx_valid), 0);
    chk("c1_wait_rx_rdy", 32'(rx_ready), 1);
    rx_valid = 1'b1;
    rx_data  = 8'h27;
    #1;
    chk("c1_wait_out_v", 32'(out_valid), 0);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    chk("c1_resp_valid", 32'(resp_valid), 1);
    chk("c1_resp_data", 32'(resp_data), 32'h27);
    chk("c1_resp_to", 32'(resp_timeout), 0);
    chk("c1_data_tx", 32'(tx_data), 32'h55);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("c1_resp_1cyc", 32'(resp_valid), 0);
    exp_tx("c1_b0", 8'h3A);
    exp_tx("c1_b1", 8'h39);
    exp_tx("c1_b2", 8'h55);
    chk("c1_len", txq.size(), 0);

    // raw 0x3D command, then timeout
    cmd_valid = 1'b1;
    cmd_data  = 8'h3D;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("c2_cmd2_data", 32'(tx_data), 32'h3D);
    @(posedge clk);
    #1;
    c0 = resp_cnt;
    repeat (15) @(posedge clk);
    #1;
    chk("to_no_early", resp_cnt, c0);
    chk("to_not_yet", 32'(resp_valid), 0);
    @(posedge clk);
    #1;
    chk("to_resp_valid", 32'(resp_valid), 1);
    chk("to_resp_to", 32'(resp_timeout), 1);
    chk("to_resp_data", 32'(resp_data), 0);
    exp_tx("c2_b0", 8'h3A);
    exp_tx("c2_b1", 8'h3D);
    chk("c2_len", txq.size(), 0);
    out_ready = 1'b1;
    rx_valid  = 1'b1;
    rx_data   = 8'hAA;
    #1;
    chk("pt_out_valid", 32'(out_valid), 1);
    chk("pt_out_data", 32'(out_data), 32'hAA);
    chk("pt_rx_ready", 32'(rx_ready), 1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    chk("pt_no_resp", 32'(resp_valid), 0);
    out_ready = 1'b0;
    #1;
    chk("pt_rx_ready_0", 32'(rx_ready), 0);

    // rx arrives in the expiry cycle
    cmd_valid = 1'b1;
    cmd_data  = 8'h5A;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    repeat (15) @(posedge clk);
    #1;
    rx_valid = 1'b1;
    rx_data  = 8'h5C;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    chk("tie_resp_valid", 32'(resp_valid), 1);
    chk("tie_resp_to", 32'(resp_timeout), 0);
    chk("tie_resp_data", 32'(resp_data), 32'h5C);
    txq.delete();

    // random back-pressure
    chk_stable = 1;
    rand_rdy   = 1;
    send(8'h3A);
    send(8'h3D);
    send(8'h10);
    cmd_valid = 1'b1;
    cmd_data  = 8'h22;
    @(negedge clk);
    chk("r_cmd_ready", 32'(cmd_ready), 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = !tx_valid;
    end
    chk("r_reach_wait", 32'(got), 1);
    rx_valid = 1'b1;
    rx_data  = 8'h01;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    chk("r_resp_valid", 32'(resp_valid), 1);
    chk("r_resp_data", 32'(resp_data), 32'h01);
    rand_rdy   = 0;
    chk_stable = 0;
    @(posedge clk);
    #1;
    tx_ready = 1'b1;
    exp_tx("r_b0", 8'h3D);
    exp_tx("r_b1", 8'h1A);
    exp_tx("r_b2", 8'h3D);
    exp_tx("r_b3", 8'h1D);
    exp_tx("r_b4", 8'h10);
    exp_tx("r_b5", 8'h3A);
    exp_tx("r_b6", 8'h22);
    chk("r_len", txq.size(), 0);

    // reset while waiting for a response
    cmd_valid = 1'b1;
    cmd_data  = 8'h11;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rw_rx_ready", 32'(rx_ready), 1);
    reset_n = 1'b0;
    #1;
    chk("rw_tx_valid", 32'(tx_valid), 0);
    chk("rw_in_ready", 32'(in_ready), 1);
    chk("rw_rx_ready0", 32'(rx_ready), 0);
    chk("rw_out_valid", 32'(out_valid), 0);
    chk("rw_cmd_ready", 32'(cmd_ready), 0);
    chk("rw_resp_valid", 32'(resp_valid), 0);
    chk("rw_resp_to", 32'(resp_timeout), 0);
    chk("rw_resp_data", 32'(resp_data), 0);
    c0 = resp_cnt;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("rw_no_resp", resp_cnt, c0);
    in_valid = 1'b1;
    in_data  = 8'h41;
    #1;
    chk("rw_idle_tx_v", 32'(tx_valid), 1);
    chk("rw_idle_tx_d", 32'(tx_data), 32'h41);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    exp_tx("rw_b0", 8'h3A);
    exp_tx("rw_b1", 8'h11);
    exp_tx("rw_b2", 8'h41);
    chk("rw_len", txq.size(), 0);

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule
